// File: rtl/color_vote_ctrl_if.sv
// Pixel-stream handshake bundle between a pixel source and color_vote_ctrl.
// The source (master) holds a pixel and its frame markers until pix_ready completes the transfer.
interface color_vote_ctrl_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;
  logic       sof;
  logic       eof;

  modport master (
    output pix_valid, pix_r, pix_g, pix_b, sof, eof,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_r, pix_g, pix_b, sof, eof,
    output pix_ready
  );
endinterface

// File: rtl/color_vote_ctrl.sv
// Dominant-color frame voter: counts red/green/blue-dominant pixels per frame and elects a winner.
// A result reaches the display code only after it repeats over AGREE consecutive frames.
//
// state  | meaning
// IDLE   | waiting for a start-of-frame pixel; other pixels are dropped
// ACCUM  | counting pixels of the current frame until eof
// DECIDE | latch this frame's candidate from the channel counts
// HOLD   | update agreement tracking, maybe commit main, pulse frame_done
module color_vote_ctrl #(
  parameter int CW      = 20,
  parameter int MIN_PIX = 16,
  parameter int AGREE   = 3
) (
  input  logic                clk,
  input  logic                reset,
  color_vote_ctrl_if.slave    pix,
  output logic [1:0]          main,
  output logic                frame_done
);

  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, HOLD} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [2:0]    AGREE_N = 3'(AGREE);

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt_r, r_cnt_g, r_cnt_b;
  logic [1:0]      r_cand, r_last_cand, r_main;
  logic [2:0]      r_agree;
  logic            r_frame_done;
  logic            w_ready, w_xfer;
  logic            w_is_r, w_is_g, w_is_b;
  logic [1:0]      w_cand;
  logic [2:0]      w_agree_next;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CW'(1);
  endfunction

  assign w_is_r = (pix.pix_r > pix.pix_g) && (pix.pix_r > pix.pix_b);
  assign w_is_g = (pix.pix_g > pix.pix_r) && (pix.pix_g > pix.pix_b);
  assign w_is_b = (pix.pix_b > pix.pix_r) && (pix.pix_b > pix.pix_g);
  assign w_xfer = pix.pix_valid && w_ready;

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = !reset;
        if (w_xfer && pix.sof) w_next = pix.eof ? DECIDE : ACCUM;
      end
      ACCUM: begin
        w_ready = !reset;
        if (w_xfer && pix.eof) w_next = DECIDE;
      end
      DECIDE:  w_next = HOLD;
      HOLD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Strict majority over both other channels, and enough pixels, or the frame is blank.
  always_comb begin
    w_cand = 2'd3;
    if (r_cnt_r > r_cnt_g && r_cnt_r > r_cnt_b && 32'(r_cnt_r) >= 32'(MIN_PIX))
      w_cand = 2'd0;
    else if (r_cnt_g > r_cnt_r && r_cnt_g > r_cnt_b && 32'(r_cnt_g) >= 32'(MIN_PIX))
      w_cand = 2'd1;
    else if (r_cnt_b > r_cnt_r && r_cnt_b > r_cnt_g && 32'(r_cnt_b) >= 32'(MIN_PIX))
      w_cand = 2'd2;
  end

  always_comb begin
    w_agree_next = 3'd1;
    if (r_cand == r_last_cand)
      w_agree_next = (r_agree >= AGREE_N) ? AGREE_N : r_agree + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_r <= '0;
      r_cnt_g <= '0;
      r_cnt_b <= '0;
    end else if (w_xfer && pix.sof) begin
      r_cnt_r <= CW'(w_is_r);
      r_cnt_g <= CW'(w_is_g);
      r_cnt_b <= CW'(w_is_b);
    end else if (w_xfer && r_state == ACCUM) begin
      if (w_is_r) r_cnt_r <= sat_inc(r_cnt_r);
      if (w_is_g) r_cnt_g <= sat_inc(r_cnt_g);
      if (w_is_b) r_cnt_b <= sat_inc(r_cnt_b);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand       <= 2'd3;
      r_last_cand  <= 2'd3;
      r_agree      <= 3'd0;
      r_main       <= 2'd3;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_state == DECIDE) r_cand <= w_cand;
      if (r_state == HOLD) begin
        r_last_cand  <= r_cand;
        r_agree      <= w_agree_next;
        r_frame_done <= 1'b1;
        if (w_agree_next == AGREE_N) r_main <= r_cand;
      end
    end
  end

  assign pix.pix_ready = w_ready;
  assign main          = r_main;
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_color_vote_ctrl.sv
// Directed bench for color_vote_ctrl: default instance plus a CW=4/AGREE=1/MIN_PIX=8 instance.
// Expected main/frame_done/pix_ready values are hand-derived from the frame contents.
module tb_color_vote_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       t_valid = 1'b0;
  logic [7:0] t_r = '0, t_g = '0, t_b = '0;
  logic       t_sof = 1'b0, t_eof = 1'b0;
  logic       sel = 1'b0;

  color_vote_ctrl_if bus0 ();
  color_vote_ctrl_if bus1 ();

  assign bus0.pix_valid = t_valid & ~sel;
  assign bus1.pix_valid = t_valid & sel;
  assign bus0.pix_r = t_r;  assign bus1.pix_r = t_r;
  assign bus0.pix_g = t_g;  assign bus1.pix_g = t_g;
  assign bus0.pix_b = t_b;  assign bus1.pix_b = t_b;
  assign bus0.sof = t_sof;  assign bus1.sof = t_sof;
  assign bus0.eof = t_eof;  assign bus1.eof = t_eof;

  logic [1:0] main0, main1;
  logic       fd0, fd1;

  color_vote_ctrl u_dut0 (
    .clk(clk), .reset(reset), .pix(bus0), .main(main0), .frame_done(fd0)
  );

  color_vote_ctrl #(.CW(4), .MIN_PIX(8), .AGREE(1)) u_dut1 (
    .clk(clk), .reset(reset), .pix(bus1), .main(main1), .frame_done(fd1)
  );

  wire       w_ready = sel ? bus1.pix_ready : bus0.pix_ready;
  wire [1:0] w_main  = sel ? main1 : main0;
  wire       w_fd    = sel ? fd1 : fd0;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] cur_main;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] r, g, b, input logic s, e);
    logic done;
    logic rdy;
    done = 1'b0;
    t_r = r; t_g = g; t_b = b; t_sof = s; t_eof = e; t_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      rdy = w_ready;
      step();
      if (rdy) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $error("FAIL xfer_timeout observed=no_ready expected=ready");
    end
  endtask

  task automatic seg(input int n, input logic [7:0] r, g, b, input logic first_sof, last_eof);
    for (int i = 0; i < n; i++)
      send(r, g, b, first_sof && i == 0, last_eof && i == n - 1);
  endtask

  // Called in the cycle right after the eof transfer edge.
  task automatic post_check(input logic [1:0] exp_main, input string tag);
    chk(w_ready, 0, {tag, "_decide_ready"});
    step();
    chk(w_ready, 0, {tag, "_hold_ready"});
    chk(w_fd, 0, {tag, "_hold_fd"});
    chk(w_main, cur_main, {tag, "_hold_main"});
    step();
    chk(w_main, exp_main, {tag, "_main"});
    chk(w_fd, 1, {tag, "_fd"});
    chk(w_ready, 1, {tag, "_idle_ready"});
    step();
    chk(w_fd, 0, {tag, "_fd_off"});
    cur_main = exp_main;
  endtask

  task automatic do_reset(input int n, input string tag);
    t_valid = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      chk(w_main, 3, {tag, "_rst_main"});
      chk(w_fd, 0, {tag, "_rst_fd"});
      chk(w_ready, 0, {tag, "_rst_ready"});
    end
    reset = 1'b0;
    step();
    chk(w_ready, 1, {tag, "_ready_after_rst"});
    cur_main = 2'd3;
  endtask

  initial begin
    cur_main = 2'd3;
    do_reset(3, "por");

    // Reset in the middle of a frame that already holds 5 red pixels.
    seg(5, 8'd200, 8'd10, 8'd10, 1'b1, 1'b0);
    do_reset(2, "mid_accum");
    seg(20, 8'd200, 8'd10, 8'd10, 1'b1, 1'b1); t_valid = 1'b0;
    post_check(2'd3, "fresh_red");

    // Three red frames from a clean agreement history.
    do_reset(1, "pre_red3");
    seg(20, 8'd200, 8'd10, 8'd10, 1'b1, 1'b1); t_valid = 1'b0;
    post_check(2'd3, "red_f1");
    seg(20, 8'd200, 8'd10, 8'd10, 1'b1, 1'b1); t_valid = 1'b0;
    post_check(2'd3, "red_f2");
    seg(20, 8'd200, 8'd10, 8'd10, 1'b1, 1'b1); t_valid = 1'b0;
    post_check(2'd0, "red_f3");

    // Blank results: low count, tie, all-neutral.
    seg(10, 8'd200, 8'd10, 8'd10, 1'b1, 1'b0);
    seg(5, 8'd10, 8'd200, 8'd10, 1'b0, 1'b1); t_valid = 1'b0;
    post_check(2'd0, "low_cnt");
    seg(20, 8'd10, 8'd200, 8'd10, 1'b1, 1'b0);
    seg(20, 8'd10, 8'd10, 8'd200, 1'b0, 1'b1); t_valid = 1'b0;
    post_check(2'd0, "tie_gb");
    seg(20, 8'd100, 8'd100, 8'd0, 1'b1, 1'b1); t_valid = 1'b0;
    post_check(2'd3, "neutral");

    // Green (after a discarded blue prefix), blue, green x3.
    seg(12, 8'd10, 8'd10, 8'd200, 1'b1, 1'b0);
    seg(20, 8'd10, 8'd200, 8'd10, 1'b1, 1'b1); t_valid = 1'b0;
    post_check(2'd3, "g_f1_resof");
    seg(20, 8'd10, 8'd10, 8'd200, 1'b1, 1'b1);
    // Next frame's first pixel is held valid across DECIDE/HOLD.
    t_r = 8'd10; t_g = 8'd200; t_b = 8'd10; t_sof = 1'b1; t_eof = 1'b0; t_valid = 1'b1;
    post_check(2'd3, "b_f2_held");
    seg(19, 8'd10, 8'd200, 8'd10, 1'b0, 1'b1); t_valid = 1'b0;
    post_check(2'd3, "g_f3");
    seg(20, 8'd10, 8'd200, 8'd10, 1'b1, 1'b1); t_valid = 1'b0;
    post_check(2'd3, "g_f4");
    seg(20, 8'd10, 8'd200, 8'd10, 1'b1, 1'b1); t_valid = 1'b0;
    post_check(2'd1, "g_f5");

    // Narrow instance: blue saturates at 15 and beats 14 red; wrap would tie at 14.
    sel = 1'b1;
    cur_main = 2'd3;
    step();
    chk(w_main, 3, "n_idle_main");
    seg(14, 8'd200, 8'd10, 8'd10, 1'b1, 1'b0);
    seg(30, 8'd10, 8'd10, 8'd200, 1'b0, 1'b1); t_valid = 1'b0;
    post_check(2'd2, "n_sat_blue");
    seg(20, 8'd200, 8'd10, 8'd10, 1'b1, 1'b1); t_valid = 1'b0;
    post_check(2'd0, "n_sat_red");
    send(8'd10, 8'd10, 8'd200, 1'b1, 1'b1); t_valid = 1'b0;
    post_check(2'd3, "n_one_pix");
    sel = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
